// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the parametrised parameter memory.
package apb_mem_pkg;

  // Sequencer states: held in reset, filling the array, normal operation.
  typedef enum logic [1:0] {
    RST  = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Fill pattern selectors.
  localparam int INIT_NONE  = 0;
  localparam int INIT_ZERO  = 1;
  localparam int INIT_IDENT = 2;

  // Width of the pattern word returned by fill_word; callers cast it down
  // (or zero-extend it) to their own data width.
  localparam int FILL_W = 64;

  // Pattern value for word idx: identity yields idx itself, everything else zero.
  function automatic logic [FILL_W-1:0] fill_word(input int mode, input logic [31:0] idx);
    logic [FILL_W-1:0] w;
    w = '0;
    if (mode == INIT_IDENT) begin
      w = {32'b0, idx};
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read data/valid delay line of RD_LAT stages. Stage 0 doubles as the
// registered read of the array; each stage only loads data when its input
// is valid, so the output holds its last value between reads.
module mem_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
    logic              vld_reg;
    logic [DATA_W-1:0] dat_reg;
    logic              src_vld;
    logic [DATA_W-1:0] src_dat;

    if (gi == 0) begin : g_src
      assign src_vld = in_valid;
      assign src_dat = in_data;
    end else begin : g_src
      assign src_vld = g_stage[gi-1].vld_reg;
      assign src_dat = g_stage[gi-1].dat_reg;
    end

    // Advance one stage; flush clears both valid and data.
    always_ff @(posedge clk) begin
      if (flush) begin
        vld_reg <= 1'b0;
        dat_reg <= '0;
      end else begin
        vld_reg <= src_vld;
        if (src_vld) begin
          dat_reg <= src_dat;
        end
      end
    end
  end

  assign out_valid = g_stage[RD_LAT-1].vld_reg;
  assign out_data  = g_stage[RD_LAT-1].dat_reg;

endmodule

// File: rtl/apb_param_memory.sv
// Single-port synchronous RAM with byte-lane writes, 1/2-cycle read
// pipeline and a hardware fill sequencer run after reset or on request.
module apb_param_memory
  import apb_mem_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                rden,
  input  logic                wren,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                init_req,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                ready,
  output logic                rd_wr_clash
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic FILL_EN = (INIT_MODE != INIT_NONE);

  state_t            state_reg;
  logic [ADDR_W:0]   init_cnt_reg;
  logic              ready_reg;
  logic              clash_reg;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc;
  logic              rd_fire;
  logic              wr_fire;
  logic              fill_we;
  logic [DATA_W-1:0] fill_data;

  // Reads win over writes when both are requested in an accepted cycle.
  assign acc       = ce & ready_reg;
  assign rd_fire   = acc & rden;
  assign wr_fire   = acc & wren & ~rden;
  assign fill_we   = (state_reg == FILL);
  assign fill_data = DATA_W'(fill_word(INIT_MODE, 32'(init_cnt_reg)));

  // Sequencer: RST -> FILL (or RUN when no pattern) -> RUN, refill on request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RST;
      init_cnt_reg <= '0;
      ready_reg    <= 1'b0;
      clash_reg    <= 1'b0;
    end else begin
      clash_reg <= acc & rden & wren;
      case (state_reg)
        RST: begin
          init_cnt_reg <= '0;
          if (FILL_EN) begin
            state_reg <= FILL;
            ready_reg <= 1'b0;
          end else begin
            state_reg <= RUN;
            ready_reg <= 1'b1;
          end
        end
        FILL: begin
          init_cnt_reg <= init_cnt_reg + 1'b1;
          if (init_cnt_reg == LAST_IDX) begin
            state_reg <= RUN;
            ready_reg <= 1'b1;
          end
        end
        RUN: begin
          if (init_req && FILL_EN) begin
            state_reg    <= FILL;
            init_cnt_reg <= '0;
            ready_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg <= RST;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  // Array write port: fill pattern while filling, otherwise lane-masked writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_we) begin
        mem[init_cnt_reg[ADDR_W-1:0]] <= fill_data;
      end else if (wr_fire) begin
        for (int k = 0; k < NB; k++) begin
          if (wr_be[k]) begin
            mem[addr][8*k +: 8] <= wr_data[8*k +: 8];
          end
        end
      end
    end
  end

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .flush     (rst),
    .in_valid  (rd_fire),
    .in_data   (mem[addr]),
    .out_valid (rd_valid),
    .out_data  (rd_data)
  );

  assign ready       = ready_reg;
  assign rd_wr_clash = clash_reg;

endmodule

// File: doc/apb_param_memory.md
Name: apb_param_memory

Overview:
- Parametrised single-port synchronous RAM. It is the next-generation backing store behind the APB slave and I2C data paths.
- Generalises width and depth, adds byte-lane write enables and a selectable 1- or 2-cycle read pipeline with a valid strobe.
- Adds a hardware initialisation sequencer that fills the array after reset or on request, so test images no longer depend on simulation-only tasks.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2.
- INIT_MODE, 1, fill pattern: 0 = none, 1 = all-zero, 2 = identity (mem[i] = i, zero-extended or truncated to DATA_W).

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  chip enable; gates all accesses.
- rden  in  1  read request.
- wren  in  1  write request.
- addr  in  ADDR_W  word address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte-lane write enables; bit k covers wr_data[8k+7:8k].
- init_req  in  1  pulse that re-runs the fill sequence.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  one-cycle strobe; rd_data is valid in that cycle.
- ready  out  1  high when the block accepts accesses.
- rd_wr_clash  out  1  one-cycle flag: rden and wren were both accepted in the same cycle.

Behaviour:
- Reset: only clk and rst are used. Every register updates on posedge clk. While rst is sampled high, rd_data = 0, rd_valid = 0, ready = 0, rd_wr_clash = 0, the pipeline is flushed, and init_cnt = 0.
- The array contents are NOT reset. They change only through writes or the fill sequence.
- FSM states: RST, FILL, RUN.
  - RST -> FILL on the first cycle after rst deasserts, if INIT_MODE != 0. Otherwise RST -> RUN.
  - FILL: one word written per cycle at init_cnt with the pattern; init_cnt increments. After the write at DEPTH-1, go to RUN. ready rises in the first RUN cycle.
  - Fill duration: DEPTH cycles, so ready is high on cycle DEPTH+1 after rst deasserts. With INIT_MODE = 0, ready is high on cycle 1.
  - RUN: init_req = 1 (with INIT_MODE != 0) -> FILL with init_cnt = 0 and ready dropping the next cycle. An access presented in that same cycle is still accepted.
  - init_req is ignored in FILL and RST, and ignored when INIT_MODE = 0.
- Accept rule: an access is accepted when ce && ready. Accesses while ready = 0 are dropped silently: no write, no rd_valid.
- Read accepted at edge T:
  - RD_LAT = 1: rd_data = mem[addr] and rd_valid = 1 after edge T, i.e. during cycle T+1.
  - RD_LAT = 2: an extra output register; rd_valid and data appear one cycle later, during cycle T+2.
  - Back-to-back reads are fully pipelined, one per cycle.
  - rd_data holds its last value when rd_valid = 0.
- Write accepted: for each lane k with wr_be[k] = 1, mem[addr] lane k <= wr_data lane k. Other lanes are unchanged. A wr_be value of all-zero is a no-op.
- Read priority: rden && wren accepted together -> the read is performed, the write is dropped, and rd_wr_clash = 1 for the next cycle.
- Read after write to the same address in the next cycle returns the new data. There is no same-cycle read-during-write case because the port is single.
- Reads pending in the pipeline when FILL starts still complete with the data fetched at accept time.
- Reset mid-FILL or mid-read: the FSM returns to RST, the pipeline is flushed with no rd_valid, and the fill restarts from address 0 afterwards.
- Address wrap: init_cnt is ADDR_W+1 bits wide; FILL terminates on reaching DEPTH, with no wrap write at address 0.

Decomposition:
- Shared package apb_mem_pkg holds:
  - the FSM state enum (RST, FILL, RUN);
  - INIT_MODE constants INIT_NONE, INIT_ZERO, INIT_IDENT;
  - a function fill_word(idx) implementing the pattern.
- One sub-module: mem_rd_pipe, a parametrised (RD_LAT) data plus valid delay line with synchronous flush.
- The array and the FSM stay in the top module.

Test Plan:
- Identity fill: DATA_W = 8, ADDR_W = 8, INIT_MODE = 2; release rst.
  - ready rises exactly 257 cycles after rst falls.
  - Reads of addr 0x00, 0x7F and 0xFF return 0x00, 0x7F and 0xFF, with rd_valid 1 cycle after accept at RD_LAT = 1.
- Byte lanes: DATA_W = 32; write 0xAABBCCDD with wr_be = 4'b1111 to addr 5, then 0x11223344 with wr_be = 4'b0101 -> read of addr 5 returns 0xAA22CC44.
- Latency and pipelining: RD_LAT = 2; read addr 1, 2, 3 on consecutive cycles -> rd_valid high for 3 consecutive cycles starting 2 cycles after the first accept, with data 1, 2, 3 in order.
- Clash: INIT_MODE = 2, addr 9; rden = wren = 1 with wr_data = 0x55 -> rd_data = 0x09, rd_wr_clash pulses for 1 cycle, and a subsequent read of addr 9 still returns 0x09.
- Gating: accesses with ce = 0, or during FILL (after init_req = 1), produce no rd_valid and no write. After refill, a previously written word (e.g. 0x5A) reads back as the identity value.
- Reset mid-fill: assert rst for 1 cycle at fill cycle 100 -> ready stays 0, and ready rises exactly DEPTH+1 cycles after the second rst release.
